// File: rtl/proc_io_pkg.sv
// Shared encodings for the Processor byte I/O peripheral.
// Holds FSM state types and the default byte width.
package proc_io_pkg;

    localparam int DATA_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_REQ  = 2'd1,
        TX_REL  = 2'd2
    } tx_state_t;

    typedef enum logic {
        RX_IDLE = 1'b0,
        RX_ACK  = 1'b1
    } rx_state_t;

endpackage

// File: rtl/byte_fifo.sv
// Small synchronous FIFO with AW+1 bit pointers.
// Head is read combinationally from registered storage.
module byte_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int AW     = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty
);

    logic [AW:0]       wptr;
    logic [AW:0]       rptr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              do_push;
    logic              do_pop;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) &&
                   (wptr[AW-1:0] == rptr[AW-1:0]);

    // Pop sees the pre-push state; a pop frees room for a push when full.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign head = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr <= '0;
            rptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wptr[AW-1:0]] <= push_data;
                wptr              <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/proc_io_peripheral.sv
// Device-side partner of the Processor byte ports: host streams
// in/out through FIFOs, Processor side via 4-phase handshakes.
module proc_io_peripheral
    import proc_io_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int DEPTH  = 4,
    parameter int AW     = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] hostTxData,
    input  logic              hostTxValid,
    output logic              hostTxReady,
    output logic [DATA_W-1:0] hostRxData,
    output logic              hostRxValid,
    input  logic              hostRxReady,
    output logic [DATA_W-1:0] procIn,
    output logic              procInDataReady,
    input  logic              procInACK,
    input  logic [DATA_W-1:0] procOut,
    input  logic              procOutDataReady,
    output logic              procOutACK
);

    logic [DATA_W-1:0] tx_head;
    logic              tx_full;
    logic              tx_empty;
    logic              tx_push;
    logic              tx_pop;
    logic [DATA_W-1:0] rx_head;
    logic              rx_full;
    logic              rx_empty;
    logic              rx_push;
    logic              rx_pop;
    logic              live;

    tx_state_t         tx_state;
    tx_state_t         tx_next;
    logic [DATA_W-1:0] in_q;
    logic [DATA_W-1:0] in_d;
    logic              rdy_q;
    logic              rdy_d;

    rx_state_t         rx_state;
    rx_state_t         rx_next;
    logic              ack_q;
    logic              ack_d;

    // Keeps hostTxReady low until the first clock after reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            live <= 1'b0;
        end else begin
            live <= 1'b1;
        end
    end

    assign hostTxReady = live && !tx_full;
    assign tx_push     = hostTxValid && hostTxReady;
    assign hostRxValid = !rx_empty;
    assign hostRxData  = rx_head;
    assign rx_pop      = hostRxValid && hostRxReady;

    byte_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_tx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (tx_push),
        .push_data (hostTxData),
        .pop       (tx_pop),
        .head      (tx_head),
        .full      (tx_full),
        .empty     (tx_empty)
    );

    byte_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_rx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (rx_push),
        .push_data (procOut),
        .pop       (rx_pop),
        .head      (rx_head),
        .full      (rx_full),
        .empty     (rx_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state <= TX_IDLE;
            in_q     <= '0;
            rdy_q    <= 1'b0;
        end else begin
            tx_state <= tx_next;
            in_q     <= in_d;
            rdy_q    <= rdy_d;
        end
    end

    always_comb begin
        tx_next = tx_state;
        in_d    = in_q;
        rdy_d   = rdy_q;
        tx_pop  = 1'b0;
        unique case (tx_state)
            TX_IDLE: begin
                if (!tx_empty) begin
                    in_d    = tx_head;
                    rdy_d   = 1'b1;
                    tx_next = TX_REQ;
                end
            end
            TX_REQ: begin
                if (procInACK) begin
                    rdy_d   = 1'b0;
                    tx_pop  = 1'b1;
                    tx_next = TX_REL;
                end
            end
            TX_REL: begin
                if (!procInACK) begin
                    tx_next = TX_IDLE;
                end
            end
            default: begin
                rdy_d   = 1'b0;
                tx_next = TX_IDLE;
            end
        endcase
    end

    assign procIn          = in_q;
    assign procInDataReady = rdy_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_state <= RX_IDLE;
            ack_q    <= 1'b0;
        end else begin
            rx_state <= rx_next;
            ack_q    <= ack_d;
        end
    end

    // procOut is captured only on the IDLE->ACK transition.
    always_comb begin
        rx_next = rx_state;
        ack_d   = ack_q;
        rx_push = 1'b0;
        unique case (rx_state)
            RX_IDLE: begin
                if (procOutDataReady && !rx_full) begin
                    rx_push = 1'b1;
                    ack_d   = 1'b1;
                    rx_next = RX_ACK;
                end
            end
            RX_ACK: begin
                if (!procOutDataReady) begin
                    ack_d   = 1'b0;
                    rx_next = RX_IDLE;
                end
            end
            default: begin
                ack_d   = 1'b0;
                rx_next = RX_IDLE;
            end
        endcase
    end

    assign procOutACK = ack_q;

endmodule

// File: tb/tb_proc_io_peripheral.sv
// Bench for proc_io_peripheral: Processor handshake models,
// host stream models and byte scoreboards in both directions.
module tb_proc_io_peripheral;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] hostTxData = 8'h00;
    logic       hostTxValid = 1'b0;
    logic       hostTxReady;
    logic [7:0] hostRxData;
    logic       hostRxValid;
    logic       hostRxReady = 1'b0;
    logic [7:0] procIn;
    logic       procInDataReady;
    logic       procInACK = 1'b0;
    logic [7:0] procOut = 8'h00;
    logic       procOutDataReady = 1'b0;
    logic       procOutACK;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];

    bit ack_mode = 1'b0;
    int rd_mode  = 0;
    int pop_req  = 0;
    int pop_done = 0;

    typedef struct {
        logic [7:0] tx;
        logic [7:0] rx;
        logic [7:0] exp_in;
        logic [7:0] exp_rx;
    } vec_t;

    vec_t vecs[20];

    always #5 clk = ~clk;

    proc_io_peripheral dut (
        .clk              (clk),
        .reset            (reset),
        .hostTxData       (hostTxData),
        .hostTxValid      (hostTxValid),
        .hostTxReady      (hostTxReady),
        .hostRxData       (hostRxData),
        .hostRxValid      (hostRxValid),
        .hostRxReady      (hostRxReady),
        .procIn           (procIn),
        .procInDataReady  (procInDataReady),
        .procInACK        (procInACK),
        .procOut          (procOut),
        .procOutDataReady (procOutDataReady),
        .procOutACK       (procOutACK)
    );

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Processor input port: ACK after 0-2 extra cycles, release later.
    always begin : in_partner
        logic [7:0] v;
        int k;
        @(negedge clk);
        if (ack_mode && procInDataReady) begin
            v = procIn;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            check("procIn held", procIn, v);
            if (tx_q.size() == 0) check("procIn spurious", procIn, 0);
            else check("procIn order", procIn, tx_q.pop_front());
            procInACK = 1'b1;
            k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (procInDataReady && k < 20);
            check("inDataReady drop", procInDataReady, 0);
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                check("no REQ under ACK", procInDataReady, 0);
            end
            procInACK = 1'b0;
        end
    end

    // Host RX side: single pops on request, or a fixed/random ready.
    always begin : rx_host
        @(negedge clk);
        #1;
        if (pop_req != pop_done) begin
            hostRxReady = hostRxValid;
            if (hostRxValid) pop_done++;
        end else if (rd_mode == 1) begin
            hostRxReady = 1'b1;
        end else if (rd_mode == 2) begin
            hostRxReady = 1'($urandom_range(0, 1));
        end else begin
            hostRxReady = 1'b0;
        end
        if (hostRxReady && hostRxValid) begin
            if (rx_q.size() == 0) check("rx spurious", hostRxData, 0);
            else check("hostRxData order", hostRxData, rx_q.pop_front());
        end
    end

    task automatic host_push(input logic [7:0] b, input logic [7:0] e);
        int k = 0;
        hostTxData  = b;
        hostTxValid = 1'b1;
        while (!hostTxReady && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!hostTxReady) check("txReady timeout", hostTxReady, 1);
        else tx_q.push_back(e);
        @(negedge clk);
        hostTxValid = 1'b0;
    endtask

    task automatic send_start(input logic [7:0] b, input logic [7:0] e);
        procOut          = b;
        procOutDataReady = 1'b1;
        rx_q.push_back(e);
    endtask

    task automatic send_finish(input int limit);
        int k = 0;
        while (!procOutACK && k < limit) begin
            @(negedge clk);
            k++;
        end
        check("outACK rise", procOutACK, 1);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        procOutDataReady = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (procOutACK && k < limit);
        check("outACK fall", procOutACK, 0);
    endtask

    task automatic drain(input int limit);
        int k = 0;
        while ((tx_q.size() != 0 || rx_q.size() != 0 ||
                procInDataReady || procInACK) && k < limit) begin
            @(negedge clk);
            k++;
        end
        check("drain tx_q", tx_q.size(), 0);
        check("drain rx_q", rx_q.size(), 0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        for (int i = 0; i < 20; i++) begin
            vecs[i].tx     = 8'(i) + 8'h30;
            vecs[i].rx     = 8'(i) + 8'hF0;
            vecs[i].exp_in = vecs[i].tx;
            vecs[i].exp_rx = vecs[i].rx;
        end

        // Power-on reset state
        repeat (2) @(negedge clk);
        check("rst txReady", hostTxReady, 0);
        check("rst rxValid", hostRxValid, 0);
        check("rst rxData", hostRxData, 0);
        check("rst procIn", procIn, 0);
        check("rst inDataReady", procInDataReady, 0);
        check("rst outACK", procOutACK, 0);
        reset = 1'b1;
        @(negedge clk);
        check("txReady after release", hostTxReady, 1);

        // 1: reset in the middle of both handshakes
        host_push(8'hA7, 8'hA7);
        send_start(8'h99, 8'h99);
        for (int k = 0; k < 10 && !procOutACK; k++) @(negedge clk);
        check("mid REQ inDataReady", procInDataReady, 1);
        check("mid REQ procIn", procIn, 8'hA7);
        check("mid ACK outACK", procOutACK, 1);
        reset            = 1'b0;
        procOutDataReady = 1'b0;
        #1;
        check("async inDataReady", procInDataReady, 0);
        check("async outACK", procOutACK, 0);
        check("async rxValid", hostRxValid, 0);
        check("async procIn", procIn, 0);
        check("async rxData", hostRxData, 0);
        check("async txReady", hostTxReady, 0);
        tx_q.delete();
        rx_q.delete();
        @(negedge clk);
        check("txReady held in reset", hostTxReady, 0);
        reset = 1'b1;
        @(negedge clk);
        check("txReady re-release", hostTxReady, 1);
        check("no REQ after reset", procInDataReady, 0);

        // 2: two TX bytes through the input handshake
        ack_mode = 1'b1;
        host_push(8'h5A, 8'h5A);
        host_push(8'hC3, 8'hC3);
        drain(100);

        // 3: RX fill, backpressure on fifth byte, in-order read
        rd_mode = 0;
        for (int i = 1; i <= 4; i++) begin
            send_start(8'(i * 8'h11), 8'(i * 8'h11));
            send_finish(20);
        end
        check("rx full valid", hostRxValid, 1);
        check("rx head", hostRxData, 8'h11);
        send_start(8'h55, 8'h55);
        repeat (4) begin
            @(negedge clk);
            check("rx backpressure", procOutACK, 0);
        end
        pop_req++;
        send_finish(20);
        rd_mode = 1;
        drain(100);
        check("rx empty after read", hostRxValid, 0);
        rd_mode = 0;

        // 4: TX FIFO fills while the Processor never ACKs
        ack_mode = 1'b0;
        for (int i = 0; i < 4; i++) host_push(8'h80 + 8'(i), 8'h80 + 8'(i));
        check("tx full ready", hostTxReady, 0);
        check("tx stuck REQ", procInDataReady, 1);
        check("tx stuck procIn", procIn, 8'h80);
        hostTxData  = 8'h84;
        hostTxValid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("tx still full", hostTxReady, 0);
        end
        ack_mode = 1'b1;
        host_push(8'h84, 8'h84);
        drain(200);
        check("tx ready after drain", hostTxReady, 1);

        // 5: RX full, pop and new DataReady in the same cycle
        for (int i = 0; i < 4; i++) begin
            send_start(8'hA0 + 8'(i), 8'hA0 + 8'(i));
            send_finish(20);
        end
        pop_req++;
        send_start(8'hA4, 8'hA4);
        @(negedge clk);
        check("outACK during pop", procOutACK, 0);
        @(negedge clk);
        check("outACK next cycle", procOutACK, 1);
        send_finish(20);
        send_start(8'hA5, 8'hA5);
        repeat (3) begin
            @(negedge clk);
            check("rx count stays 4", procOutACK, 0);
        end
        rd_mode = 1;
        send_finish(50);
        drain(100);

        // 6: concurrent streaming across pointer wrap
        rd_mode = 2;
        fork
            begin
                for (int i = 0; i < 20; i++)
                    host_push(vecs[i].tx, vecs[i].exp_in);
            end
            begin
                for (int i = 0; i < 20; i++) begin
                    send_start(vecs[i].rx, vecs[i].exp_rx);
                    send_finish(100);
                end
            end
        join
        drain(2000);
        rd_mode = 0;
        repeat (3) @(negedge clk);
        check("idle rxValid", hostRxValid, 0);
        check("idle inDataReady", procInDataReady, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
